r5p_htif_responder: RTL and testbench
=====================================

# r5p_htif_responder

Synthesizable HTIF end-of-test responder for the R5P cores, sitting as a TCB-lite subordinate beside main memory on the CPU system bus. It decodes a small tohost/fromhost register window, answers loads and stores with the bus's fixed one-cycle response delay, and detects the test-completion write. It reports pass, fail, or timeout to FPGA pins or a bench, with no simulation-only tasks.

## Interface
- XLEN, 32, data/address width
- ADR_BASE, 32'h8000_1000, window base; 16-byte aligned
- TIMEOUT, 20000, RUN-state cycle limit; 0 disables the limit
- CNT_W, 32, timeout counter width
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low (asserted at 0)
- tcb_vld  in  1  request valid
- tcb_wen  in  1  write enable
- tcb_adr  in  XLEN  byte address
- tcb_siz  in  2  log2 transfer size; 0 byte, 1 half, 2 word, 3 illegal
- tcb_wdt  in  XLEN  write data, LSB-aligned
- tcb_rdy  out  1  request ready
- tcb_rdt  out  XLEN  read data, valid one cycle after the transfer
- tcb_err  out  1  error, valid one cycle after the transfer
- frh_vld  in  1  host-side fromhost write strobe
- frh_dat  in  2*XLEN  host-side fromhost value
- sts_hlt  out  1  test finished (pass, fail or timeout)
- sts_pas  out  1  test passed
- sts_tmo  out  1  timeout occurred
- sts_cod  out  XLEN-1  exit code (tohost[XLEN-1:1])

## Operation
- Transfer: tcb_vld & tcb_rdy. tcb_rdy is constant 1; there is no backpressure in any state.
- Decode window: tcb_adr[XLEN-1:4] == ADR_BASE[XLEN-1:4]. Register select is tcb_adr[3:2]: 0 tohost lo, 1 tohost hi, 2 fromhost lo, 3 fromhost hi.
- Error conditions (tcb_err=1, tcb_rdt=0, no register update):
  - address outside the window
  - siz==3
  - misaligned access (adr[0] for half; adr[1:0] for word)
- Byte/half writes update only the addressed lanes.
- Reads return the full 32-bit word, unshifted; the CPU extracts the lanes.
- State machine, encoded on sts_*:
  - RUN → PASS: store to tohost lo with wdt[0]=1 and wdt[XLEN-1:1]==0.
  - RUN → FAIL: same store with wdt[XLEN-1:1]!=0. sts_cod captures wdt[XLEN-1:1].
  - RUN → TMO: counter reaches TIMEOUT-1 while in RUN.
  - PASS, FAIL and TMO are terminal until reset. In them the window still responds to bus reads and writes, but the tohost trigger is ignored.
- The trigger write also stores its value into tohost lo. A tohost write with wdt[0]=0 is only a register update.
- A byte/half write reaching bit 0 with bit 0 set counts as a trigger. The exit code is taken from the merged register value.
- fromhost: a host write (frh_vld) loads both words.
  - On the same cycle as a CPU write to fromhost, the host write wins.
  - On the same cycle as a CPU read of fromhost, the read returns the pre-update value.
- Trigger store and timeout terminal count on the same cycle: trigger wins (PASS/FAIL).

## Timing
- Response latency: exactly 1 cycle. tcb_rdt/tcb_err are registered from the transfer cycle and held until the next transfer.
- State outputs are registered: sts_* change 1 cycle after the triggering transfer.
- Timeout counter:
  - counts clk cycles while in RUN, starting with the first cycle after rst deasserts;
  - saturates at TIMEOUT-1;
  - TIMEOUT=20000 gives sts_tmo in cycle 20000 after reset release.
- Reset values: tcb_rdy=1, tcb_rdt=0, tcb_err=0, all sts_*=0, tohost=0, fromhost=0, counter=0, state RUN.
- Reset mid-operation clears everything asynchronously. A transfer in flight is dropped, and no response is driven after reset.

## Configuration
- R5P_HTIF_TIMEOUT_EN defined: counter and TMO state are built, and TIMEOUT is honoured.
- Not defined: no counter logic, sts_tmo tied to 0, TMO unreachable, TIMEOUT ignored.

## Structure
- Package r5p_htif_pkg:
  - state enum (RUN, PASS, FAIL, TMO);
  - register offset constants (OFS_TOH_LO=0, OFS_TOH_HI=4, OFS_FRH_LO=8, OFS_FRH_HI=12);
  - a lane-merge function (size/offset → byte mask).
- One sub-module, r5p_htif_timer: saturating counter with enable and terminal-count output. It is instantiated only under R5P_HTIF_TIMEOUT_EN.

## Test plan
- Pass: sw 0x0000_0001 to 0x8000_1000 → next cycle sts_hlt=1, sts_pas=1, sts_cod=0; later reads of 0x8000_1000 return 0x0000_0001.
- Fail: sw 0x0000_0007 → sts_hlt=1, sts_pas=0, sts_cod=3; later triggers with other values do not change sts_cod.
- Timeout with TIMEOUT=100, macro defined, no bus traffic → sts_tmo=1 and sts_hlt=1 exactly 100 cycles after reset release. With the macro undefined, sts_tmo stays 0 indefinitely.
- Errors:
  - lw from 0x8000_2000 → next cycle tcb_err=1, tcb_rdt=0;
  - sh to 0x8000_1009 → tcb_err=1 and fromhost unchanged;
  - siz=3 → tcb_err=1.
- Lanes and collision:
  - sb 0xA5 to 0x8000_100B → lw 0x8000_1008 returns 0xA500_0000;
  - frh_vld with 0x1_0000_0002 on the same cycle as sw 0xFFFF_FFFF to 0x8000_1008 → fromhost lo reads 0x0000_0002, fromhost hi reads 0x0000_0001.
- Async reset asserted between a lw transfer and its response → tcb_rdt=0 and tcb_err=0 immediately; after release the state is RUN and the counter restarts from 0.

Source files
------------

// File: rtl/r5p_htif_pkg.sv
// Shared types and helpers for the HTIF end-of-test responder.
// Holds the state encoding, register offsets and the store lane-mask helper.
package r5p_htif_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2,
    TMO  = 2'd3
  } htif_state_t;

  localparam logic [3:0] OFS_TOH_LO = 4'd0;
  localparam logic [3:0] OFS_TOH_HI = 4'd4;
  localparam logic [3:0] OFS_FRH_LO = 4'd8;
  localparam logic [3:0] OFS_FRH_HI = 4'd12;

  // Byte lanes touched by an access of size siz at byte offset ofs within a word.
  function automatic logic [3:0] lane_mask(input logic [1:0] siz, input logic [1:0] ofs);
    case (siz)
      2'd0:    lane_mask = 4'b0001 << ofs;
      2'd1:    lane_mask = 4'b0011 << ofs;
      2'd2:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/r5p_htif_timer.sv
// Saturating cycle counter; tc is high while the count sits at LIMIT-1.
// Latency: tc is a combinational view of the count register. No backpressure.
// LIMIT=0 disables the terminal count.
module r5p_htif_timer #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned LIMIT = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = (LIMIT != 0) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/r5p_htif_responder.sv
// HTIF tohost/fromhost responder on TCB-lite; reports pass/fail/timeout (timeout built with R5P_HTIF_TIMEOUT_EN).
// Latency: read data/error one cycle after the transfer; status one cycle after the trigger.
// Backpressure: none, tcb_rdy is tied high.
module r5p_htif_responder
  import r5p_htif_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] ADR_BASE = 32'h8000_1000,
  parameter int unsigned     TIMEOUT  = 20000,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tcb_vld,
  input  logic              tcb_wen,
  input  logic [XLEN-1:0]   tcb_adr,
  input  logic [1:0]        tcb_siz,
  input  logic [XLEN-1:0]   tcb_wdt,
  output logic              tcb_rdy,
  output logic [XLEN-1:0]   tcb_rdt,
  output logic              tcb_err,
  input  logic              frh_vld,
  input  logic [2*XLEN-1:0] frh_dat,
  output logic              sts_hlt,
  output logic              sts_pas,
  output logic              sts_tmo,
  output logic [XLEN-2:0]   sts_cod
);

  localparam logic [1:0] SEL_TOH_LO = OFS_TOH_LO[3:2];
  localparam logic [1:0] SEL_TOH_HI = OFS_TOH_HI[3:2];
  localparam logic [1:0] SEL_FRH_LO = OFS_FRH_LO[3:2];
  localparam logic [1:0] SEL_FRH_HI = OFS_FRH_HI[3:2];

  htif_state_t     state_q, state_d;
  logic [XLEN-1:0] toh_lo, toh_hi, frh_lo, frh_hi;
  logic [XLEN-2:0] cod;

  logic            hit, mis, bad, wr, rd, trig, tmo_tc;
  logic [1:0]      sel;
  logic [3:0]      bm;
  logic [XLEN-1:0] wmask, wsh, cur, mrg;

  assign tcb_rdy = 1'b1;

  assign hit = tcb_adr[XLEN-1:4] == ADR_BASE[XLEN-1:4];
  assign mis = ((tcb_siz == 2'd1) && tcb_adr[0]) ||
               ((tcb_siz == 2'd2) && (tcb_adr[1:0] != 2'd0));
  assign bad = !hit || (tcb_siz == 2'd3) || mis;
  assign wr  = tcb_vld && tcb_wen && !bad;
  assign rd  = tcb_vld && !tcb_wen && !bad;
  assign sel = tcb_adr[3:2];
  assign bm  = lane_mask(tcb_siz, tcb_adr[1:0]);
  assign wsh = tcb_wdt << {tcb_adr[1:0], 3'b000};

  always_comb begin
    wmask = '0;
    for (int b = 0; b < 4; b++) begin
      wmask[8*b +: 8] = {8{bm[b]}};
    end
  end

  always_comb begin
    cur = toh_lo;
    case (sel)
      SEL_TOH_LO: cur = toh_lo;
      SEL_TOH_HI: cur = toh_hi;
      SEL_FRH_LO: cur = frh_lo;
      SEL_FRH_HI: cur = frh_hi;
      default:    cur = toh_lo;
    endcase
  end

  assign mrg = (cur & ~wmask) | (wsh & wmask);

  // Only a store that actually writes byte 0 can finish the test.
  assign trig = wr && (sel == SEL_TOH_LO) && bm[0] && mrg[0];

`ifdef R5P_HTIF_TIMEOUT_EN
  r5p_htif_timer #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .en  (state_q == RUN),
    .tc  (tmo_tc)
  );
`else
  logic unused_cfg;
  assign unused_cfg = TIMEOUT[0] ^ CNT_W[0];
  assign tmo_tc     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (trig) begin
          state_d = (mrg[XLEN-1:1] == '0) ? PASS : FAIL;
        end else if (tmo_tc) begin
          state_d = TMO;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcb_rdt <= '0;
      tcb_err <= 1'b0;
      toh_lo  <= '0;
      toh_hi  <= '0;
      frh_lo  <= '0;
      frh_hi  <= '0;
      cod     <= '0;
    end else begin
      if (tcb_vld) begin
        tcb_err <= bad;
        tcb_rdt <= rd ? cur : '0;
      end
      if (wr && (sel == SEL_TOH_LO)) toh_lo <= mrg;
      if (wr && (sel == SEL_TOH_HI)) toh_hi <= mrg;
      // Host update takes priority over a colliding CPU store to fromhost.
      if (frh_vld) begin
        frh_lo <= frh_dat[XLEN-1:0];
        frh_hi <= frh_dat[2*XLEN-1:XLEN];
      end else begin
        if (wr && (sel == SEL_FRH_LO)) frh_lo <= mrg;
        if (wr && (sel == SEL_FRH_HI)) frh_hi <= mrg;
      end
      if ((state_q == RUN) && trig) cod <= mrg[XLEN-1:1];
    end
  end

  assign sts_hlt = state_q != RUN;
  assign sts_pas = state_q == PASS;
  assign sts_tmo = state_q == TMO;
  assign sts_cod = cod;

endmodule

// File: tb/tb_r5p_htif_responder.sv
// Bench for r5p_htif_responder: directed and random bus/host traffic against a byte-level model.
module tb_r5p_htif_responder;

  localparam int unsigned TIMEOUT = 100;
  localparam logic [31:0] BASE    = 32'h8000_1000;
`ifdef R5P_HTIF_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk, rst;
  logic        tcb_vld, tcb_wen, tcb_rdy, tcb_err;
  logic [31:0] tcb_adr, tcb_wdt, tcb_rdt;
  logic [1:0]  tcb_siz;
  logic        frh_vld;
  logic [63:0] frh_dat;
  logic        sts_hlt, sts_pas, sts_tmo;
  logic [30:0] sts_cod;

  r5p_htif_responder #(
    .XLEN     (32),
    .ADR_BASE (BASE),
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tcb_vld (tcb_vld),
    .tcb_wen (tcb_wen),
    .tcb_adr (tcb_adr),
    .tcb_siz (tcb_siz),
    .tcb_wdt (tcb_wdt),
    .tcb_rdy (tcb_rdy),
    .tcb_rdt (tcb_rdt),
    .tcb_err (tcb_err),
    .frh_vld (frh_vld),
    .frh_dat (frh_dat),
    .sts_hlt (sts_hlt),
    .sts_pas (sts_pas),
    .sts_tmo (sts_tmo),
    .sts_cod (sts_cod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdt;
    logic        err;
    logic        hlt;
    logic        pas;
    logic        tmo;
    logic [30:0] cod;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: 0 run, 1 pass, 2 fail, 3 timeout.
  logic [31:0] m_reg[4];
  int          m_st;
  logic [30:0] m_cod;
  logic [31:0] m_rdt;
  logic        m_err;
  int          m_cyc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 32'h0;
    m_st = 0; m_cod = '0; m_rdt = '0; m_err = 1'b0; m_cyc = 0;
  endtask

  task automatic model(input logic v, input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic [31:0] d, input logic fv, input logic [63:0] fd);
    exp_t        e;
    logic [31:0] nv, code;
    int          idx, off, n;
    bit          trig;
    trig = 0; code = '0;
    m_cyc++;
    if (v) begin
      off = int'(a % 4);
      n   = 1 << s;
      if ((a >> 4) != (BASE >> 4) || s == 2'd3 || (a % n) != 0) begin
        m_err = 1'b1; m_rdt = '0;
      end else begin
        idx   = int'((a % 16) / 4);
        m_err = 1'b0;
        m_rdt = w ? 32'h0 : m_reg[idx];
        if (w) begin
          nv = m_reg[idx];
          for (int i = 0; i < n; i++) nv[8*(off+i) +: 8] = d[8*i +: 8];
          if (!(fv && idx >= 2)) m_reg[idx] = nv;
          if (idx == 0 && off == 0 && nv[0]) begin
            trig = 1; code = nv >> 1;
          end
        end
      end
    end
    if (fv) begin
      m_reg[2] = fd[31:0];
      m_reg[3] = fd[63:32];
    end
    if (m_st == 0) begin
      if (trig) begin
        m_st  = (code == 0) ? 1 : 2;
        m_cod = code[30:0];
      end else if (TMO_EN && TIMEOUT != 0 && m_cyc >= TIMEOUT) begin
        m_st = 3;
      end
    end
    e.rdt = m_rdt; e.err = m_err;
    e.hlt = (m_st != 0); e.pas = (m_st == 1); e.tmo = (m_st == 3); e.cod = m_cod;
    q.push_back(e);
  endtask

  task automatic idle();
    tcb_vld = 0; tcb_wen = 0; tcb_adr = '0; tcb_siz = 2'd2; tcb_wdt = '0;
    frh_vld = 0; frh_dat = '0;
  endtask

  // One clock of stimulus; entered and left at posedge+1.
  task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [1:0] s,
                      input logic [31:0] d, input logic fv, input logic [63:0] fd);
    tcb_vld = v; tcb_wen = w; tcb_adr = a; tcb_siz = s; tcb_wdt = d;
    frh_vld = fv; frh_dat = fd;
    model(v, w, a, s, d, fv, fd);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b0;
    idle();
    #1;
    chk("rst_rdy", tcb_rdy, 1);
    chk("rst_rdt", tcb_rdt, 0);
    chk("rst_err", tcb_err, 0);
    chk("rst_sts", {sts_hlt, sts_pas, sts_tmo, sts_cod}, 0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic rnd_step();
    logic [31:0] a, d;
    logic [1:0]  s;
    int          r;
    a = BASE | 32'($urandom_range(0, 15));
    if ($urandom_range(0, 19) == 0) a = $urandom;
    r = $urandom_range(0, 9);
    s = (r == 0) ? 2'd3 : 2'(r % 3);
    if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
    d = $urandom;
    if ($urandom_range(0, 9) != 0) d[0] = 1'b0;
    if ($urandom_range(0, 29) == 0) d = 32'h1;
    step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, s, d,
         $urandom_range(0, 7) == 0, {$urandom, $urandom});
  endtask

  // Monitor: one expected entry per clock edge after reset release.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        @(negedge clk);
        chk("rdy", tcb_rdy, 1);
        chk("rdt", tcb_rdt, e.rdt);
        chk("err", tcb_err, e.err);
        chk("hlt", sts_hlt, e.hlt);
        chk("pas", sts_pas, e.pas);
        chk("tmo", sts_tmo, e.tmo);
        chk("cod", sts_cod, e.cod);
      end
    end
  end

  initial begin
    rst = 1'b0;
    idle();
    model_reset();
    do_reset();

    // pass, then a later trigger is ignored
    step(1, 1, BASE, 2, 32'h1, 0, 0);
    step(1, 0, BASE, 2, 0, 0, 0);
    step(1, 1, BASE, 2, 32'h7, 0, 0);
    step(1, 0, BASE, 2, 0, 0, 0);
    step(0, 0, 0, 2, 0, 0, 0);
    do_reset();

    // fail with code 3; second trigger keeps the code
    step(1, 1, BASE, 2, 32'h7, 0, 0);
    step(1, 1, BASE, 2, 32'h9, 0, 0);
    step(1, 0, BASE, 2, 0, 0, 0);
    do_reset();

    // error responses
    step(1, 0, 32'h8000_2000, 2, 0, 0, 0);
    step(0, 0, 0, 2, 0, 1, 64'h1234_5678_9abc_def0);
    step(1, 1, 32'h8000_1009, 1, 32'hbeef, 0, 0);
    step(1, 0, 32'h8000_1008, 2, 0, 0, 0);
    step(1, 0, 32'h8000_1004, 3, 0, 0, 0);
    step(1, 0, 32'h8000_1002, 2, 0, 0, 0);
    do_reset();

    // lanes, host/CPU collision, partial-write trigger
    step(1, 1, 32'h8000_100B, 0, 32'hA5, 0, 0);
    step(1, 0, 32'h8000_1008, 2, 0, 0, 0);
    step(1, 1, 32'h8000_1008, 2, 32'hFFFF_FFFF, 1, 64'h1_0000_0002);
    step(1, 0, 32'h8000_1008, 2, 0, 0, 0);
    step(1, 0, 32'h8000_100C, 2, 0, 0, 0);
    step(1, 1, 32'h8000_1001, 0, 32'h01, 0, 0);
    step(1, 1, 32'h8000_1000, 1, 32'h0003, 0, 0);
    step(1, 0, BASE, 2, 0, 0, 0);
    do_reset();

    for (int r = 0; r < 3; r++) begin
      repeat (150) rnd_step();
      do_reset();
    end

    // read in flight when reset hits, then idle past the timeout
    step(0, 0, 0, 2, 0, 1, 64'hdead_beef_0bad_f00d);
    step(1, 0, 32'h8000_100C, 2, 0, 0, 0);
    do_reset();
    repeat (TIMEOUT + 20) step(0, 0, 0, 2, 0, 0, 0);

    @(negedge clk); #2;
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
